// File: rtl/ils_instr_gen.sv
`timescale 1ns/1ps
// Random RV32I instruction source for a core's imem response path: NOP warmup, then LFSR-driven
// ALU-imm/load/store words through a registered valid/ready slot; a stalled slot holds its word.
module ils_instr_gen #(
  parameter logic [31:0] SEED       = 32'h000002F0,
  parameter int unsigned WARMUP     = 4,
  parameter int unsigned MAX_INSTRS = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [1:0]  instr_kind,
  output logic [15:0] instr_count,
  output logic        done
);

  localparam logic [31:0] NOP      = 32'h00000013;
  localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [31:0] WARM_N   = 32'(WARMUP);
  localparam logic [31:0] MAX_N    = 32'(MAX_INSTRS);

  typedef enum logic [1:0] {S_WARMUP, S_RUN, S_DONE} state_t;
  localparam state_t RESET_STATE = (WARMUP == 0) ? S_RUN : S_WARMUP;

  state_t      state, state_nxt;
  logic [31:0] lfsr, lfsr_next;
  logic [31:0] warm_cnt, run_cnt;
  logic        accept, slot_free, load, load_nop, valid_nxt, done_nxt;

  logic [11:0] imm, imm_alu;
  logic [4:0]  rs1, rd, rs2;
  logic [2:0]  funct3, funct3_l;
  logic [1:0]  sel;
  logic [31:0] rand_word;
  logic [1:0]  rand_kind;

  assign accept    = instr_valid && instr_ready;
  assign slot_free = !instr_valid || accept;
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h80200003 : 32'h0);

  assign imm      = lfsr_next[11:0];
  assign rs1      = lfsr_next[16:12];
  assign rd       = lfsr_next[21:17];
  assign funct3   = lfsr_next[24:22];
  assign rs2      = lfsr_next[29:25];
  assign sel      = lfsr_next[31:30];
  assign funct3_l = {lfsr_next[24], 2'b00};

  // Shift immediates keep only legal shamt bits (plus the SRA selector bit for funct3=5).
  always_comb begin
    imm_alu = imm;
    if (funct3 == 3'd5)
      imm_alu = imm & 12'h41F;
    else if (funct3 == 3'd1)
      imm_alu = imm & 12'h01F;
  end

  always_comb begin
    rand_word = {imm, rs1, funct3_l, rd, 7'b0000011};
    rand_kind = 2'd2;
    if (sel[1]) begin
      rand_word = {imm_alu, rs1, funct3, rd, 7'b0010011};
      rand_kind = 2'd1;
    end else if (sel[0]) begin
      rand_word = {imm[11:5], rs2, rs1, 3'b000, imm[4:0], 7'b0100011};
      rand_kind = 2'd3;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    load_nop  = 1'b0;
    case (state)
      S_WARMUP: begin
        if (slot_free && en) begin
          load     = 1'b1;
          load_nop = 1'b1;
          if (warm_cnt == WARM_N - 32'd1)
            state_nxt = (MAX_N == 32'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        // Covers MAX_INSTRS=0 when reset lands directly in RUN.
        if (run_cnt >= MAX_N) begin
          state_nxt = S_DONE;
        end else if (slot_free && en) begin
          load = 1'b1;
          if (run_cnt == MAX_N - 32'd1)
            state_nxt = S_DONE;
        end
      end
      default: ;
    endcase
    valid_nxt = load ? 1'b1 : (accept ? 1'b0 : instr_valid);
    done_nxt  = done || ((state_nxt == S_DONE) && !valid_nxt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RESET_STATE;
      lfsr        <= SEED_EFF;
      warm_cnt    <= 32'd0;
      run_cnt     <= 32'd0;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_kind  <= 2'd0;
      instr_count <= 16'd0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      instr_valid <= valid_nxt;
      done        <= done_nxt;
      if (load) begin
        if (load_nop) begin
          instr      <= NOP;
          instr_kind <= 2'd0;
          warm_cnt   <= warm_cnt + 32'd1;
        end else begin
          instr      <= rand_word;
          instr_kind <= rand_kind;
          lfsr       <= lfsr_next;
          run_cnt    <= run_cnt + 32'd1;
        end
      end
      if (accept && (instr_kind != 2'd0))
        instr_count <= instr_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ils_instr_gen.sv
`timescale 1ns/1ps
// Bench for ils_instr_gen: directed phases plus random en/ready traffic against a sequence model.
module tb_ils_instr_gen;

  logic        clk, reset, en, instr_ready;
  logic        instr_valid, done;
  logic [31:0] instr;
  logic [1:0]  instr_kind;
  logic [15:0] instr_count;
  logic        valid0, done0;
  logic [31:0] instr0;
  logic [1:0]  kind0;
  logic [15:0] count0;

  int total = 0;
  int bad   = 0;

  ils_instr_gen dut (
    .clk(clk), .reset(reset), .en(en), .instr_ready(instr_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_kind(instr_kind),
    .instr_count(instr_count), .done(done)
  );

  ils_instr_gen #(.WARMUP(0), .MAX_INSTRS(0)) dut0 (
    .clk(clk), .reset(reset), .en(en), .instr_ready(instr_ready),
    .instr_valid(valid0), .instr(instr0), .instr_kind(kind0),
    .instr_count(count0), .done(done0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference sequence: the n-th word the generator should offer, plus accepted totals.
  int unsigned m_lfsr;
  int          m_idx, m_rand;
  logic [31:0] m_word;
  logic [1:0]  m_kind;
  logic [15:0] m_cnt;
  logic [31:0] acc_q[$];
  logic        hold;
  logic [31:0] hold_word;
  logic [1:0]  hold_kind;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_gen();
    int unsigned imm, rs1, rd, f3, rs2, sel, immv;
    if (m_idx < 4) begin
      m_word = 32'h00000013;
      m_kind = 2'd0;
    end else begin
      m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 32'h80200003 : 32'h0);
      imm = m_lfsr % 4096;
      rs1 = (m_lfsr >> 12) % 32;
      rd  = (m_lfsr >> 17) % 32;
      f3  = (m_lfsr >> 22) % 8;
      rs2 = (m_lfsr >> 25) % 32;
      sel = m_lfsr >> 30;
      if (sel >= 2) begin
        immv = (f3 == 5) ? (imm & 32'h41F) : ((f3 == 1) ? (imm & 32'h1F) : imm);
        m_word = (immv << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
        m_kind = 2'd1;
      end else if (sel == 1) begin
        m_word = ((imm >> 5) << 25) | (rs2 << 20) | (rs1 << 15) | ((imm % 32) << 7) | 32'h23;
        m_kind = 2'd3;
      end else begin
        m_word = (imm << 20) | (rs1 << 15) | (((f3 >> 2) * 4) << 12) | (rd << 7) | 32'h03;
        m_kind = 2'd2;
      end
    end
  endtask

  task automatic model_reset();
    m_lfsr = 32'h000002F0;
    m_idx  = 0;
    m_rand = 0;
    m_cnt  = 16'd0;
    model_gen();
  endtask

  task automatic model_pop();
    if (m_kind != 2'd0) begin
      m_rand++;
      m_cnt = m_cnt + 16'd1;
    end
    m_idx++;
    model_gen();
  endtask

  // One clock: score the handshake that the coming edge completes, then check the new state.
  task automatic tick();
    logic acc;
    acc = !reset && instr_valid && instr_ready;
    if (!reset && instr_valid) begin
      chk("slot_word", instr, m_word);
      chk("slot_kind", 32'(instr_kind), 32'(m_kind));
    end
    if (acc) begin
      acc_q.push_back(instr);
      if (instr_kind == 2'd1 && instr[14:12] == 3'd5)
        chk("srai_imm_bits", 32'(instr[31:20] & 12'hBE0), 32'd0);
      if (instr_kind == 2'd1 && instr[14:12] == 3'd1)
        chk("slli_imm_bits", 32'(instr[31:25]), 32'd0);
      if (instr_kind == 2'd2)
        chk("load_funct3", 32'(instr[13:12]), 32'd0);
      model_pop();
    end
    hold      = !reset && instr_valid && !instr_ready;
    hold_word = instr;
    hold_kind = instr_kind;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (hold) begin
        chk("hold_valid", 32'(instr_valid), 32'd1);
        chk("hold_word", instr, hold_word);
        chk("hold_kind", 32'(instr_kind), 32'(hold_kind));
      end
      chk("count", 32'(instr_count), 32'(m_cnt));
      chk("done", 32'(done), 32'(m_rand == 100));
      if (m_rand == 100)
        chk("valid_after_done", 32'(instr_valid), 32'd0);
      chk("dut0_valid", 32'(valid0), 32'd0);
    end
  endtask

  task automatic run_directed(input string tag);
    logic [31:0] exp_w [6];
    exp_w = '{32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013,
              32'h17800003, 32'h0BC00003};
    acc_q.delete();
    en = 1'b1;
    instr_ready = 1'b1;
    repeat (12) tick();
    chk({tag, "_accepts"}, 32'(acc_q.size()), 32'd11);
    for (int i = 0; i < 6; i++)
      chk({tag, "_word"}, acc_q[i], exp_w[i]);
    chk({tag, "_count"}, 32'(instr_count), 32'd7);
  endtask

  initial begin
    logic [15:0] cnt_before;
    logic [31:0] held;
    reset = 1'b1;
    en = 1'b0;
    instr_ready = 1'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h00000013);
    chk("rst_kind", 32'(instr_kind), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_done", 32'(done), 32'd0);

    reset = 1'b0;
    repeat (2) tick();
    chk("no_valid_without_en", 32'(instr_valid), 32'd0);

    run_directed("first");

    en = 1'b1;
    instr_ready = 1'b0;
    cnt_before = instr_count;
    held = instr;
    repeat (5) tick();
    chk("stall_count", 32'(instr_count), 32'(cnt_before));
    chk("stall_word", instr, held);
    instr_ready = 1'b1;
    tick();
    chk("release_word", acc_q[$], held);

    for (int c = 0; c < 4000 && m_rand < 37; c++) begin
      en = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    instr_ready = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 10 && !instr_valid; c++) tick();
    chk("mid_count", 32'(instr_count), 32'd37);
    chk("mid_valid", 32'(instr_valid), 32'd1);
    reset = 1'b1;
    tick();
    chk("mid_rst_valid", 32'(instr_valid), 32'd0);
    chk("mid_rst_count", 32'(instr_count), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    model_reset();
    run_directed("replay");

    for (int c = 0; c < 20000 && m_rand < 100; c++) begin
      en = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    chk("final_count", 32'(instr_count), 32'd100);
    chk("final_done", 32'(done), 32'd1);
    chk("final_valid", 32'(instr_valid), 32'd0);
    en = 1'b1;
    instr_ready = 1'b1;
    repeat (5) begin
      tick();
      chk("post_done_valid", 32'(instr_valid), 32'd0);
      chk("post_done_sticky", 32'(done), 32'd1);
    end
    chk("dut0_done", 32'(done0), 32'd1);
    chk("dut0_count", 32'(count0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ils_instr_gen.md
ILS_INSTR_GEN -- requirements
Module: ils_instr_gen

Interface
REQ-001 SHALL have parameter SEED, default 32'h000002F0, initial LFSR state (0 treated as 32'h00000001).
REQ-002 SHALL have parameter WARMUP, default 4, number of NOPs issued before random instructions.
REQ-003 SHALL have parameter MAX_INSTRS, default 100, number of random instructions issued before done.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  permits loading a new instruction into the output slot.
REQ-007 SHALL have port instr_ready  input  1  consumer (imem response path) accepts instr this cycle.
REQ-008 SHALL have port instr_valid  output  1  instr holds a valid instruction.
REQ-009 SHALL have port instr  output  32  RV32I instruction word to the core's imem response data.
REQ-010 SHALL have port instr_kind  output  2  0 NOP, 1 ALU-imm, 2 load, 3 store.
REQ-011 SHALL have port instr_count  output  16  number of random (non-NOP) instructions accepted.
REQ-012 SHALL have port done  output  1  sticky; all MAX_INSTRS random instructions accepted.

Function
REQ-013 SHALL hold a registered output slot (instr, instr_kind, instr_valid); accept = instr_valid && instr_ready.
REQ-014 SHALL keep instr and instr_kind stable while instr_valid=1 and instr_ready=0.
REQ-015 SHALL load the slot in a cycle when (instr_valid=0 or accept) and en=1 and state is WARMUP or RUN; back-to-back accepts give one instruction per cycle, no bubbles.
REQ-016 SHALL clear instr_valid after accept when no load occurs (en=0 or state DONE-pending).
REQ-017 SHALL implement states WARMUP, RUN, DONE; WARMUP -> RUN after WARMUP NOPs loaded; RUN -> DONE after MAX_INSTRS random instructions loaded; DONE terminal until reset.
REQ-018 SHALL enter RUN directly from reset when WARMUP=0, and DONE directly from WARMUP completion when MAX_INSTRS=0.
REQ-019 SHALL load NOP 32'h00000013, kind 0, in WARMUP without advancing the LFSR.
REQ-020 SHALL in RUN advance the LFSR per load: S' = (S>>1) ^ (S[0] ? 32'h80200003 : 0), and encode from S'.
REQ-021 SHALL slice fields from S': imm=S'[11:0], rs1=S'[16:12], rd=S'[21:17], funct3=S'[24:22], rs2=S'[29:25], sel=S'[31:30], funct3_l={S'[24],2'b00}.
REQ-022 SHALL mask ALU imm: funct3=5 -> imm & 12'h41F; funct3=1 -> imm & 12'h01F; otherwise unmasked.
REQ-023 SHALL encode sel[1]=1 as {imm,rs1,funct3,rd,7'b0010011} kind 1; sel=01 as {imm[11:5],rs2,rs1,3'b000,imm[4:0],7'b0100011} kind 3; sel=00 as {imm,rs1,funct3_l,rd,7'b0000011} kind 2.
REQ-024 SHALL increment instr_count (16-bit, wraps at 65535 -> 0) on each accept of kind != 0.
REQ-025 SHALL assert done the cycle after the accept of the MAX_INSTRS-th random instruction; instr_valid=0 thereafter.
REQ-026 SHALL ignore instr_ready while instr_valid=0; en falling does not retract an already-valid instr.

Reset
REQ-027 SHALL on reset set instr_valid=0, instr=32'h00000013, instr_kind=0, instr_count=0, done=0, LFSR=SEED, state=WARMUP (or RUN if WARMUP=0), counters 0.
REQ-028 SHALL let reset override any pending handshake, including mid-RUN with instr_valid=1; post-reset sequence SHALL be bit-identical to the first.
REQ-029 SHALL present the first valid instr no earlier than the first cycle after reset deasserts with en=1.

Verification
REQ-030 Defaults, en=1, ready=1 held: 4 accepts of 32'h00000013 kind 0, then 32'h17800003 kind 2, then 32'h0BC00003 kind 2.
REQ-031 Ready low 5 cycles with valid=1: instr, kind unchanged all 5 cycles; instr_count unchanged; releases with same word accepted once.
REQ-032 Run to completion: instr_count=100, done=1 cycle after 100th random accept, instr_valid=0 and stays 0 with ready=1.
REQ-033 Reset asserted mid-RUN (instr_count=37, valid=1): next cycle valid=0, count=0, done=0; replay reproduces REQ-030 sequence.
REQ-034 Every kind-1 word with funct3=5 has instr[31:20] & 12'hBE0 == 0; funct3=1 has instr[31:25]==0; every kind-2 word has funct3 in {0,4}.
REQ-035 WARMUP=0, MAX_INSTRS=0: done=1 with no accepted instruction; instr_valid never asserts.
